mem_bus_arbiter: RTL and testbench

- Shares the single-ported system memory (RAM low, ROM high) between two requesters: the 6502 core (port 0) and a DMA/debug loader (port 1).
- Sequences each access:
  - arbitration;
  - ROM/RAM decode;
  - region-specific wait states;
  - completion strobe.
- Sits between the core/loader and the memory array inside top.
- Enforces read-only ROM and bounded DMA starvation.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported RAM/ROM array between the 6502 core (port 0) and the
// DMA/debug loader (port 1), inserting region wait states and write-protecting ROM.
module mem_bus_arbiter #(
    parameter logic [15:0] ROM_BASE   = 16'hF000,
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        ph1,
    input  logic        resetb,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata,
    output logic [1:0]  gnt,
    output logic        rom_wr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_rom_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] RAM_W      = 3'(RAM_WAIT);
    localparam logic [2:0] ROM_W      = 3'(ROM_WAIT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        rom_q, rom_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;

    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            rom_q    <= 1'b0;
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            rom_q    <= rom_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        rom_d    = rom_q;
        wait_d   = wait_q;
        starve_d = starve_q;

        unique case (state_q)
            ST_IDLE: begin
                // The loader wins when the core is idle or has used up its starvation budget.
                if (req1 && (!req0 || starve_q == STARVE_LIM)) begin
                    gnt_d    = 2'b10;
                    addr_d   = addr1;
                    wdata_d  = wdata1;
                    we_d     = we1;
                    rom_d    = (addr1 >= ROM_BASE);
                    starve_d = '0;
                    state_d  = ST_ACCESS;
                end else if (req0) begin
                    gnt_d   = 2'b01;
                    addr_d  = addr0;
                    wdata_d = wdata0;
                    we_d    = we0;
                    rom_d   = (addr0 >= ROM_BASE);
                    if (req1 && starve_q < STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                wait_d  = rom_q ? ROM_W : RAM_W;
                state_d = (wait_d == 3'd0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registered state so an async reset clears them at once.
    assign mem_en      = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
    assign mem_we      = (state_q == ST_ACCESS) && we_q && !rom_q;
    assign mem_addr    = mem_en ? addr_q : 16'h0000;
    assign mem_rom_sel = mem_en && rom_q;
    assign mem_wdata   = mem_we ? wdata_q : 8'h00;
    assign gnt         = gnt_q;
    assign done0       = (state_q == ST_DONE) && gnt_q[0];
    assign done1       = (state_q == ST_DONE) && gnt_q[1];
    assign rom_wr_err  = (state_q == ST_DONE) && we_q && rom_q;
    assign rdata       = ((state_q == ST_DONE) && !we_q) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed plus randomized transactions checked against a
// transaction-level model (grant rule, latency, memory image, ROM protection).
module tb_mem_bus_arbiter;

    localparam logic [15:0] M_ROM_BASE = 16'hF000;
    localparam int M_RAM_WAIT = 0;
    localparam int M_ROM_WAIT = 1;
    localparam int M_STARVE   = 4;

    logic        ph1;
    logic        resetb;
    logic        req [2];
    logic [15:0] addr [2];
    logic [7:0]  wdata [2];
    logic        we [2];
    logic        done0, done1, rom_wr_err, mem_en, mem_we, mem_rom_sel;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [1:0]  gnt;
    logic [15:0] mem_addr;

    // Second instance with swapped wait-state parameters, used only for latency checks.
    logic        r2Req;
    logic [15:0] r2Addr;
    logic        d2Done0, d2Done1, d2Err, d2En, d2We, d2Sel;
    logic [7:0]  d2Rdata, d2Wdata;
    logic [1:0]  d2Gnt;
    logic [15:0] d2Addr;

    logic [7:0]  memArr [65536];
    logic [7:0]  refMem [65536];

    int          vectors = 0;
    int          miscompares = 0;
    int          starveModel = 0;
    logic [7:0]  lastRd = 8'h00;
    bit          holdHigh = 0;
    bit          pend [2];
    logic [15:0] pAddr [2];
    logic [7:0]  pData [2];
    bit          pWe [2];
    int          gntLog [$];

    mem_bus_arbiter u_dut (
        .ph1(ph1), .resetb(resetb),
        .req0(req[0]), .req1(req[1]),
        .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .we0(we[0]), .we1(we[1]),
        .done0(done0), .done1(done1), .rdata(rdata), .gnt(gnt),
        .rom_wr_err(rom_wr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_rom_sel(mem_rom_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.RAM_WAIT(3), .ROM_WAIT(0)) u_dut2 (
        .ph1(ph1), .resetb(resetb),
        .req0(r2Req), .req1(1'b0),
        .addr0(r2Addr), .addr1(16'h0000),
        .wdata0(8'h00), .wdata1(8'h00),
        .we0(1'b0), .we1(1'b0),
        .done0(d2Done0), .done1(d2Done1), .rdata(d2Rdata), .gnt(d2Gnt),
        .rom_wr_err(d2Err), .mem_en(d2En), .mem_we(d2We),
        .mem_rom_sel(d2Sel), .mem_addr(d2Addr),
        .mem_wdata(d2Wdata), .mem_rdata(8'h5A)
    );

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    // Memory array: one-cycle read latency; the bench trusts mem_we for ROM too,
    // so a leaked ROM write would corrupt the byte and show up on read-back.
    always @(posedge ph1) begin
        if (mem_en) begin
            if (mem_we) memArr[mem_addr] <= mem_wdata;
            mem_rdata <= memArr[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveReqs();
        for (int p = 0; p < 2; p++) begin
            req[p]   = pend[p];
            addr[p]  = pAddr[p];
            wdata[p] = pData[p];
            we[p]    = pWe[p];
        end
    endtask

    task automatic setReq(input int p, input logic [15:0] a, input bit w, input logic [7:0] d);
        pend[p]  = 1'b1;
        pAddr[p] = a;
        pWe[p]   = w;
        pData[p] = d;
        driveReqs();
    endtask

    function automatic logic [15:0] randAddr();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 255));
            1:       return 16'hEFF8 + 16'($urandom_range(0, 15));
            2:       return 16'hFFF0 + 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at the negedge of an IDLE cycle with at least one request pending.
    task automatic applyStimulus();
        int         winner;
        int         lat;
        bit         rom;
        logic [2:0] expFlags;
        winner = (pend[1] && (!pend[0] || starveModel == M_STARVE)) ? 1 : 0;
        if (winner == 1) starveModel = 0;
        else if (pend[1] && starveModel < M_STARVE) starveModel++;
        rom = (pAddr[winner] >= M_ROM_BASE);
        lat = 2 + (rom ? M_ROM_WAIT : M_RAM_WAIT);
        if (!pWe[winner]) lastRd = refMem[pAddr[winner]];
        else if (!rom) refMem[pAddr[winner]] = pData[winner];
        expFlags = {pWe[winner] && rom, winner == 1, winner == 0};
        for (int k = 1; k <= lat; k++) begin
            @(negedge ph1);
            if (k == 1) begin
                checkOutput("gnt", 32'(gnt), (winner == 1) ? 32'd2 : 32'd1);
                checkOutput("mem_addr", 32'(mem_addr), 32'(pAddr[winner]));
                checkOutput("mem_rom_sel", 32'(mem_rom_sel), 32'(rom));
                checkOutput("mem_we_access", 32'(mem_we), 32'(pWe[winner] && !rom));
            end else if (k < lat) begin
                checkOutput("mem_we_wait", 32'(mem_we), 32'd0);
            end
            if (k < lat) begin
                checkOutput("mem_en_busy", 32'(mem_en), 32'd1);
                checkOutput("early_done", 32'({rom_wr_err, done1, done0}), 32'd0);
            end else begin
                checkOutput("done_flags", 32'({rom_wr_err, done1, done0}), 32'(expFlags));
                checkOutput("rdata", 32'(rdata), 32'(lastRd));
                checkOutput("mem_en_done", 32'(mem_en), 32'd0);
            end
        end
        gntLog.push_back(winner);
        pend[winner] = holdHigh;
        if (holdHigh) begin
            pAddr[winner] = 16'($urandom_range(0, 16'hEFFF));
            pWe[winner]   = 1'b0;
        end
        driveReqs();
        @(negedge ph1);
        checkOutput("idle_after_done", 32'({gnt, done1, done0}), 32'd0);
    endtask

    task automatic drain();
        while (pend[0] || pend[1]) applyStimulus();
    endtask

    task automatic measureLatency(input logic [15:0] a, output int lat);
        lat    = 11;
        r2Req  = 1'b1;
        r2Addr = a;
        for (int k = 1; k <= 10; k++) begin
            @(negedge ph1);
            if (d2Done0) begin
                lat = k;
                break;
            end
        end
        r2Req = 1'b0;
        @(negedge ph1);
    endtask

    initial begin
        int lat;
        int expOrder [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        resetb = 1'b0;
        r2Req  = 1'b0;
        r2Addr = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pAddr[p] = '0; pWe[p] = 0; pData[p] = '0;
        end
        driveReqs();
        for (int i = 0; i < 65536; i++) begin
            memArr[i] = 8'($urandom);
            refMem[i] = memArr[i];
        end
        memArr[16'hFFFC] = 8'h00; refMem[16'hFFFC] = 8'h00;
        memArr[16'hFFFD] = 8'hF0; refMem[16'hFFFD] = 8'hF0;

        repeat (2) @(negedge ph1);
        checkOutput("reset_outputs", 32'({gnt, done1, done0, rom_wr_err, mem_en, mem_we}), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        resetb = 1'b1;
        @(negedge ph1);

        measureLatency(16'h0200, lat);
        checkOutput("dut2_ram_latency", 32'(lat), 32'(2 + 3));
        measureLatency(16'hFFF0, lat);
        checkOutput("dut2_rom_latency", 32'(lat), 32'(2 + 0));

        $display("[TB] reset vector fetch");
        setReq(0, 16'hFFFC, 0, 8'h00); applyStimulus();
        setReq(0, 16'hFFFD, 0, 8'h00); applyStimulus();

        $display("[TB] RAM write/readback and ROM protection");
        setReq(0, 16'h0080, 1, 8'h1F); applyStimulus();
        setReq(0, 16'h0080, 0, 8'h00); applyStimulus();
        setReq(1, 16'hF000, 1, 8'hAA); applyStimulus();
        setReq(1, 16'hF000, 0, 8'h00); applyStimulus();
        setReq(1, 16'hEFFF, 1, 8'h3C); applyStimulus();
        setReq(1, 16'hEFFF, 0, 8'h00); applyStimulus();

        $display("[TB] starvation bound");
        gntLog.delete();
        holdHigh = 1;
        setReq(0, 16'h0010, 0, 8'h00);
        setReq(1, 16'h0020, 0, 8'h00);
        repeat (10) applyStimulus();
        holdHigh = 0;
        drain();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("grant_order_%0d", i), 32'(gntLog[i]), 32'(expOrder[i]));
        end

        $display("[TB] randomized traffic");
        for (int r = 0; r < 60; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    setReq(p, randAddr(), bit'($urandom_range(0, 1)), 8'($urandom));
                end
            end
            if (pend[0] || pend[1]) begin
                applyStimulus();
            end else begin
                @(negedge ph1);
                checkOutput("idle_no_req", 32'({gnt, done1, done0, mem_en}), 32'd0);
            end
        end
        drain();

        $display("[TB] reset during ROM wait state");
        setReq(0, 16'hF100, 0, 8'h00);
        repeat (2) @(negedge ph1);
        checkOutput("pre_reset_busy", 32'({gnt, mem_en}), 32'b011);
        resetb = 1'b0;
        #1;
        checkOutput("async_reset_clear", 32'({gnt, done1, done0, mem_en}), 32'd0);
        pend[0] = 0;
        driveReqs();
        starveModel = 0;
        lastRd = 8'h00;
        @(negedge ph1);
        resetb = 1'b1;
        repeat (4) begin
            @(negedge ph1);
            checkOutput("post_reset_idle", 32'({gnt, done1, done0, mem_en, rom_wr_err}), 32'd0);
        end
        checkOutput("post_reset_rdata", 32'(rdata), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
